fp_div_issue: RTL and testbench
===============================

# fp_div_issue

Operand issue and result-capture controller placed directly in front of the FP divider datapath (`FP_Divider`). It accepts single-precision operand pairs over a valid/ready handshake and classifies them (zero, inf, NaN, denormal, exponent over/underflow). Normal operands are driven into the divider with its `en` asserted, and the divider's registered result is captured one cycle later. Special cases bypass the divider with IEEE-754 results, so downstream logic sees one uniform valid/ready result stream.

## Interface
- `DW`, 32, operand/result width
- `EX_DW`, 8, exponent width
- `MAN_DW`, 23, stored mantissa width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `in_a`  in  DW  dividend (IEEE single)
- `in_b`  in  DW  divisor
- `div_a`  out  DW  to divider `A`
- `div_b`  out  DW  to divider `B`
- `div_en`  out  1  to divider `en`
- `div_c`  in  DW  from divider registered output `C`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_c`  out  DW  quotient
- `out_flags`  out  4  {invalid, div_by_zero, overflow, underflow}; present only with `FP_DIV_FLAGS_EN`

## Operation
- FSM states: IDLE, ISSUE, CAPT, HOLD.
- **IDLE:** `in_ready`=1. On `in_valid`, latch `in_a`/`in_b` into the operand registers and classify.
  - Normal class → ISSUE.
  - Special class → load `out_c` with the special result and go to HOLD.
- **ISSUE:** `div_en`=1 for exactly one cycle. The divider registers the quotient at the closing edge. Next state is CAPT.
- **CAPT:** `out_c` ← `div_c`. Next state is HOLD.
- **HOLD:** `out_valid`=1, and `out_c`/`out_flags` are stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` = `out_ready` in HOLD. A simultaneous `in_valid` is accepted and classified exactly as in IDLE, giving back-to-back operation.
- `div_a`/`div_b` always equal the operand registers. `div_en`=0 outside ISSUE.
- Classification, with denormals flushed to zero (exp==0 → zero) and s = sign_a ^ sign_b:
  - Either operand NaN, 0/0, or inf/inf → 0x7FC00000, invalid.
  - inf/finite → {s, 0xFF, 0}.
  - nonzero finite/0 → {s, 0xFF, 0}, div_by_zero.
  - 0/nonzero, or finite/inf → {s, 0x00, 0}.
  - Otherwise compute e = ea − eb + 127 − (ma < mb) in 10-bit signed arithmetic (ma/mb are the 23-bit mantissas):
    - e ≥ 255 → {s, 0xFF, 0}, overflow.
    - e ≤ 0 → {s, 0x00, 0}, underflow.
    - else normal class.
- `out_c` is a register, not a combinational path.

## Timing
- Reset (async, `rst`=0): state IDLE, `in_ready`=0 while reset is asserted then 1, `out_valid`=0, `out_c`=0, `out_flags`=0, `div_en`=0, operand regs=0.
- Normal latency: accept edge T0 → ISSUE cycle T0+1 → CAPT T0+2 → `out_valid` high from T0+3.
- Special latency: `out_valid` high from T0+1.
- Throughput is one result per 3 cycles (normal) or 1 cycle (special) when `out_ready` is held high.
- Backpressure: while `out_ready`=0 in HOLD, `out_valid`, `out_c` and `out_flags` hold and no new input is accepted.
- Reset mid-operation (ISSUE/CAPT/HOLD): the in-flight result is discarded. `div_en` drops immediately. No `out_valid` after release until a new accept.

## Configuration
- `FP_DIV_FLAGS_EN` defined:
  - `out_flags` port exists.
  - Flags are registered alongside `out_c`, held with it, and cleared to 0 for normal results.
- `FP_DIV_FLAGS_EN` undefined:
  - No `out_flags` port and no flag registers.
  - Result values and timing are identical.

## Test plan
- 6.0/2.0: `in_a`=0x40C00000, `in_b`=0x40000000, `out_ready`=1 → `div_en` pulses one cycle at T0+1, `out_c`=0x40400000 with `out_valid` at T0+3, flags 0.
- 1.0/0: 0x3F800000 / 0x00000000 → 0x7F800000 at T0+1, `div_en` never asserted, flags=0b0100. Same with sign: 0xBF800000/0 → 0xFF800000.
- 0/0 and inf/inf (0x7F800000/0x7F800000) → 0x7FC00000, flags=0b1000. Denormal 0x00000001/0x3F800000 → 0x00000000.
- Overflow/underflow:
  - 0x7F000000 / 0x00800000 → 0x7F800000, flags 0b0010.
  - 0x00800000 / 0x7F000000 → 0x00000000, flags 0b0001.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 5 cycles in HOLD → `out_c` stable, `in_ready`=0.
  - Then raise `out_ready` with a new `in_valid` → both handshakes complete on the same edge, and the second result follows at the correct latency.
- Reset: assert `rst`=0 during ISSUE → `div_en`, `out_valid` and `out_c` go 0 asynchronously. After release, no result appears until a new operand pair is accepted.

Source files
------------

// File: rtl/fp_div_issue.sv
// fp_div_issue -- operand issue / result capture controller for FP_Divider.
//
// Accepts single-precision operand pairs on a valid/ready handshake and
// classifies them. Ordinary operands are presented to the divider with a
// one-cycle en pulse, and the divider's registered quotient is captured on the
// following cycle. Zero, inf, NaN, flushed denormals and out-of-range
// exponents skip the divider and load the IEEE-754 result directly, so the
// downstream consumer always sees one valid/ready result stream.
//
// Optional feature macro: FP_DIV_FLAGS_EN (adds out_flags and its register).
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   in_valid/ready   operand handshake
//   in_a, in_b       dividend / divisor (IEEE single)
//   div_a, div_b     operand registers, wired to divider A/B
//   div_en           divider enable, high only in the ISSUE cycle
//   div_c            divider registered quotient C
//   out_valid/ready  result handshake
//   out_c            registered quotient
//   out_flags        {invalid, div_by_zero, overflow, underflow}
//                    (only with FP_DIV_FLAGS_EN)

module fp_div_issue #(
    parameter int DW     = 32,
    parameter int EX_DW  = 8,
    parameter int MAN_DW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] div_a,
    output logic [DW-1:0] div_b,
    output logic          div_en,
    input  logic [DW-1:0] div_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_c
`ifdef FP_DIV_FLAGS_EN
    ,
    output logic [3:0]    out_flags
`endif
);

    localparam logic [EX_DW-1:0]  EXP_MAX = {EX_DW{1'b1}};
    localparam logic [EX_DW-1:0]  EXP_ZRO = '0;
    localparam logic [MAN_DW-1:0] MAN_ZRO = '0;
    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    localparam logic [DW-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_DW-1){1'b0}}};
    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic signed [9:0] E_OVF   = 10'sd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Operand field decode (on the raw inputs, so the class is known on
    // the accept edge itself)
    // ------------------------------------------------------------------
    logic              sign_q;
    logic [EX_DW-1:0]  ea, eb;
    logic [MAN_DW-1:0] ma, mb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [9:0] exp_q;

    logic c_invalid, c_inf, c_dbz, c_zero, c_ovf, c_unf, finite_nz;
    logic special;
    logic [DW-1:0] spec_c;

    always_comb begin
        sign_q = in_a[DW-1] ^ in_b[DW-1];
        ea     = in_a[DW-2 -: EX_DW];
        eb     = in_b[DW-2 -: EX_DW];
        ma     = in_a[MAN_DW-1:0];
        mb     = in_b[MAN_DW-1:0];

        // Denormals are flushed: any zero exponent counts as zero.
        a_zero = (ea == EXP_ZRO);
        b_zero = (eb == EXP_ZRO);
        a_inf  = (ea == EXP_MAX) && (ma == MAN_ZRO);
        b_inf  = (eb == EXP_MAX) && (mb == MAN_ZRO);
        a_nan  = (ea == EXP_MAX) && (ma != MAN_ZRO);
        b_nan  = (eb == EXP_MAX) && (mb != MAN_ZRO);

        // Quotient exponent; one less when the mantissa quotient is < 1,
        // because the divider then normalises by one place.
        exp_q = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS
              - $signed({9'b0, (ma < mb)});

        // Mutually exclusive classes, evaluated in priority order.
        c_invalid = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
        c_inf     = !c_invalid && a_inf;
        c_dbz     = !c_invalid && !a_inf && b_zero;
        c_zero    = !c_invalid && !a_inf && !b_zero && (a_zero || b_inf);
        finite_nz = !c_invalid && !c_inf && !c_dbz && !c_zero;
        c_ovf     = finite_nz && (exp_q >= E_OVF);
        c_unf     = finite_nz && (exp_q <= 10'sd0);

        special = c_invalid || c_inf || c_dbz || c_zero || c_ovf || c_unf;

        if (c_invalid)
            spec_c = QNAN;
        else if (c_inf || c_dbz || c_ovf)
            spec_c = {sign_q, EXP_MAX, MAN_ZRO};
        else
            spec_c = {sign_q, EXP_ZRO, MAN_ZRO};
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        div_en    = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                // Held low during reset even though state is already IDLE.
                in_ready = rst;
                accept   = in_valid && rst;
                if (accept)
                    state_nx = special ? HOLD : ISSUE;
            end
            ISSUE: begin
                div_en   = 1'b1;
                state_nx = CAPT;
            end
            CAPT: begin
                state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                // A new pair can only enter on the same edge the current
                // result leaves, which keeps out_c stable under backpressure.
                in_ready  = out_ready;
                accept    = in_valid && out_ready;
                if (accept)
                    state_nx = special ? HOLD : ISSUE;
                else if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_a <= '0;
            div_b <= '0;
        end else if (accept) begin
            div_a <= in_a;
            div_b <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out_c <= '0;
        else if (accept && special)
            out_c <= spec_c;
        else if (state == CAPT)
            out_c <= div_c;
    end

`ifdef FP_DIV_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out_flags <= 4'b0000;
        else if (accept && special)
            out_flags <= {c_invalid, c_dbz, c_ovf, c_unf};
        else if (state == CAPT)
            out_flags <= 4'b0000;
    end
`endif

endmodule

// File: tb/tb_fp_div_issue.sv
module tb_fp_div_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, div_en;
    logic [31:0] in_a, in_b, div_a, div_b, div_c, out_c;
`ifdef FP_DIV_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    always #5 clk = ~clk;

    fp_div_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .div_a(div_a), .div_b(div_b), .div_en(div_en), .div_c(div_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c)
`ifdef FP_DIV_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Divider stand-in: truncating mantissa divide, registered when en is
    // high; otherwise the output wanders so a mistimed capture is visible.
    function automatic logic [31:0] mock_div(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] na, nb, q;
        int e;
        na = {40'b0, 1'b1, a[22:0]};
        nb = {40'b0, 1'b1, b[22:0]};
        if (na >= nb) q = (na << 23) / nb;
        else          q = (na << 24) / nb;
        e = int'(a[30:23]) - int'(b[30:23]) + 127 - ((na < nb) ? 1 : 0);
        return {a[31] ^ b[31], e[7:0], q[22:0]};
    endfunction

    always @(posedge clk) begin
        if (div_en) div_c <= mock_div(div_a, div_b);
        else        div_c <= $urandom;
    end

    // Reference: returns {goes_to_divider, flags[3:0], result[31:0]}.
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e;
        logic s, az, bz, ai, bi, an, bn;
        logic [31:0] inf_r, zero_r;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        inf_r  = {s, 8'hFF, 23'd0};
        zero_r = {s, 31'd0};
        if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 4'b1000, 32'h7FC00000};
        if (ai)        return {1'b0, 4'b0000, inf_r};
        if (bz)        return {1'b0, 4'b0100, inf_r};
        if (az || bi)  return {1'b0, 4'b0000, zero_r};
        e = ea - eb + 127 - ((a[22:0] < b[22:0]) ? 1 : 0);
        if (e >= 255)  return {1'b0, 4'b0010, inf_r};
        if (e <= 0)    return {1'b0, 4'b0001, zero_r};
        return {1'b1, 4'b0000, mock_div(a, b)};
    endfunction

    function automatic logic [31:0] gen_op();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: r[30:0] = 31'd0;
            1: r[30:0] = {8'hFF, 23'd0};
            2: r[30:0] = {8'hFF, r[22:1], 1'b1};
            3: r[30:23] = 8'h00;
            4: ;
            default: r[30:23] = 8'(100 + $urandom_range(0, 54));
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitor, sampling on the falling edge
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          en_due = -100;
    logic [31:0] en_a, en_b, held_c;
    bit          head_started = 0, held = 0, mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            en_due = -100;
            head_started = 0;
            held = 0;
        end else if (mon_en) begin
            chk("div_en_timing", {35'd0, div_en}, {35'd0, (cyc == en_due)});
            if (div_en) begin
                chk("div_a", {4'd0, div_a}, {4'd0, en_a});
                chk("div_b", {4'd0, div_b}, {4'd0, en_b});
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 36'd1, 36'd0);
                end else begin
                    if (!head_started) begin
                        head_started = 1;
                        chk("latency", 36'(cyc), 36'(q[0].due));
                    end
                    if (held) chk("hold_c", {4'd0, out_c}, {4'd0, held_c});
                    if (out_ready) begin
                        chk("out_c", {4'd0, out_c}, {4'd0, q[0].c});
`ifdef FP_DIV_FLAGS_EN
                        chk("out_flags", {32'd0, out_flags}, {32'd0, q[0].f});
`endif
                        void'(q.pop_front());
                        head_started = 0;
                        held = 0;
                    end else begin
                        chk("in_ready_bp", {35'd0, in_ready}, 36'd0);
                        held = 1;
                        held_c = out_c;
                    end
                end
            end else if (held) begin
                chk("hold_valid", 36'd0, 36'd1);
                held = 0;
            end
            if (in_valid && in_ready) begin
                logic [36:0] m;
                exp_t e;
                m = model(in_a, in_b);
                e.c = m[31:0];
                e.f = m[35:32];
                e.due = cyc + (m[36] ? 3 : 1);
                q.push_back(e);
                if (m[36]) begin
                    en_due = cyc + 1;
                    en_a = in_a;
                    en_b = in_b;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed single transfer: checks latency, result and flags
    // ------------------------------------------------------------------
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ec, input logic [3:0] ef, input int lat);
        int k;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin k = i; break; end
        end
        chk({tag, "_lat"}, 36'(k), 36'(lat));
        chk({tag, "_c"}, {4'd0, out_c}, {4'd0, ec});
`ifdef FP_DIV_FLAGS_EN
        chk({tag, "_f"}, {32'd0, out_flags}, {32'd0, ef});
`else
        if (ef === 4'hx) $display("unreachable");
`endif
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        #1;
        chk("rst_in_ready",  {35'd0, in_ready},  36'd0);
        chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
        chk("rst_div_en",    {35'd0, div_en},    36'd0);
        chk("rst_out_c",     {4'd0, out_c},      36'd0);
        chk("rst_div_a",     {4'd0, div_a},      36'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; mon_en = 1;
        @(negedge clk);
        chk("idle_in_ready", {35'd0, in_ready}, 36'd1);

        run_one("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 3);
        run_one("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
        run_one("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1);
        run_one("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        run_one("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1);
        run_one("denorm", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1);
        run_one("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 1);
        run_one("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 1);

        // Backpressure then back-to-back
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
        @(posedge clk); #1;
        in_a = 32'h3F800000; in_b = 32'h00000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {35'd0, out_valid}, 36'd1);
            chk("bp_c", {4'd0, out_c}, {4'd0, 32'h40400000});
            chk("bp_in_ready", {35'd0, in_ready}, 36'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_both", {34'd0, in_ready, out_valid}, 36'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_valid", {35'd0, out_valid}, 36'd1);
        chk("b2b_second_c", {4'd0, out_c}, {4'd0, 32'h7F800000});

        // Reset while in ISSUE
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_div_en",    {35'd0, div_en},    36'd0);
        chk("mid_rst_out_valid", {35'd0, out_valid}, 36'd0);
        chk("mid_rst_out_c",     {4'd0, out_c},      36'd0);
        chk("mid_rst_in_ready",  {35'd0, in_ready},  36'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_no_valid", {35'd0, out_valid}, 36'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = gen_op();
            in_b      = gen_op();
            out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 36'(q.size()), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
